// File: rtl/uart_reg_pkg.sv
// Shared definitions for the UART register bank: register offsets,
// pixel emitter states, pixel packing modes and status word layout.
package uart_reg_pkg;

  // Byte offsets of the word-addressed register map
  localparam logic [7:0] REG_VER  = 8'h00;
  localparam logic [7:0] REG_DATE = 8'h04;
  localparam logic [7:0] REG_VGA  = 8'h08;
  localparam logic [7:0] REG_SEL  = 8'h0C;
  localparam logic [7:0] REG_IMG  = 8'h10;
  localparam logic [7:0] REG_BASE = 8'h14;
  localparam logic [7:0] REG_STAT = 8'h18;
  localparam logic [7:0] REG_PTR  = 8'h1C;

  // Pixel emitter states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EMIT0 = 2'd1,
    EMIT1 = 2'd2
  } pix_state_t;

  // Pixel packing of a write to the image-data register
  localparam int PIX_565   = 0;  // one RGB565 pixel in DATA[15:0]
  localparam int PIX_888   = 1;  // one RGB888 pixel in DATA[23:0], truncated
  localparam int PIX_565X2 = 2;  // two RGB565 pixels, low half first

  // Status register layout
  localparam int ST_WRAP_BIT    = 16;
  localparam int ST_BUSY_BIT    = 17;
  localparam int ST_CNT_CLR_BIT = 31;

  // True for an aligned offset that falls inside the register map
  function automatic logic reg_is_mapped(input logic [7:0] off);
    return (off[1:0] == 2'b00) && (off <= REG_PTR);
  endfunction

  // True for registers that reject writes
  function automatic logic reg_is_ro(input logic [7:0] off);
    return (off == REG_VER) || (off == REG_DATE) || (off == REG_PTR);
  endfunction

endpackage

// File: rtl/img_pix_emitter.sv
// Turns an accepted image-data word into one or two pixel strobes and
// owns the auto-incrementing frame-store pointer with its wrap detect.
module img_pix_emitter
  import uart_reg_pkg::*;
#(
  parameter int IMG_AW    = 18,
  parameter int IMG_DEPTH = 2**18,
  parameter int PIX_MODE  = PIX_565
) (
  input  logic              CLK_100M,
  input  logic              SYS_RST,
  input  logic              i_start,
  input  logic [31:0]       i_word,
  input  logic              i_load,
  input  logic [IMG_AW-1:0] i_load_addr,
  output logic              o_dvld,
  output logic [15:0]       o_data,
  output logic [IMG_AW-1:0] o_addr,
  output logic [IMG_AW-1:0] o_ptr,
  output logic              o_busy,
  output logic              o_wrap
);

  localparam logic [IMG_AW-1:0] PTR_LAST = IMG_AW'(IMG_DEPTH - 1);

  pix_state_t        r_state;
  pix_state_t        w_state_next;
  logic [15:0]       r_pix0;
  logic [15:0]       r_pix1;
  logic [15:0]       r_hold_data;
  logic [IMG_AW-1:0] r_ptr;
  logic [IMG_AW-1:0] r_hold_addr;
  logic [15:0]       w_pix0;
  logic [15:0]       w_pix;
  logic              w_emit;

  // First pixel of the incoming word, converted to RGB565
  always_comb begin
    if (PIX_MODE == PIX_888) begin
      w_pix0 = {i_word[23:19], i_word[15:10], i_word[7:3]};
    end else begin
      w_pix0 = i_word[15:0];
    end
  end

  // Next state and strobe: every non-idle state emits exactly one pixel
  always_comb begin
    w_state_next = r_state;
    w_emit       = (r_state != IDLE);
    w_pix        = (r_state == EMIT1) ? r_pix1 : r_pix0;
    case (r_state)
      IDLE:    if (i_start) w_state_next = EMIT0;
      EMIT0:   w_state_next = (PIX_MODE == PIX_565X2) ? EMIT1 : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register; reset abandons any pixel still pending
  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Word capture, pointer advance (a base load wins) and output hold
  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_pix0      <= '0;
      r_pix1      <= '0;
      r_ptr       <= '0;
      r_hold_data <= '0;
      r_hold_addr <= '0;
    end else begin
      if ((r_state == IDLE) && i_start) begin
        r_pix0 <= w_pix0;
        r_pix1 <= i_word[31:16];
      end
      if (i_load) begin
        r_ptr <= i_load_addr;
      end else if (w_emit) begin
        r_ptr <= (r_ptr == PTR_LAST) ? '0 : r_ptr + IMG_AW'(1);
      end
      if (w_emit) begin
        r_hold_data <= w_pix;
        r_hold_addr <= r_ptr;
      end
    end
  end

  // Live pixel while strobing, otherwise the last emitted one
  assign o_dvld = w_emit;
  assign o_data = w_emit ? w_pix : r_hold_data;
  assign o_addr = w_emit ? r_ptr : r_hold_addr;
  assign o_ptr  = r_ptr;
  assign o_busy = w_emit;
  assign o_wrap = w_emit && !i_load && (r_ptr == PTR_LAST);

endmodule

// File: rtl/uart_reg_bank_v2.sv
// Control/status register bank between the UART command controller and
// the VGA / frame-store path: decode, registers, acks and error tracking.
module uart_reg_bank_v2
  import uart_reg_pkg::*;
#(
  parameter int          AW        = 8,
  parameter int          DW        = 32,
  parameter int          IMG_AW    = 18,
  parameter int          IMG_DEPTH = 2**18,
  parameter int          PIX_MODE  = PIX_565,
  parameter logic [31:0] VERSION   = 32'h0002_0000,
  parameter logic [31:0] DATE      = 32'h0000_0000
) (
  input  logic              CLK_100M,
  input  logic              SYS_RST,
  input  logic [1:0]        UART_STATE,
  input  logic [AW-1:0]     UART_ADDR,
  input  logic [DW-1:0]     UART_DATA,
  output logic [1:0]        REG_STATE,
  output logic [DW-1:0]     REG_DATA,
  output logic              REG_ERR,
  output logic              REG_VGA_EN,
  output logic [1:0]        REG_SELECT,
  output logic              REG_IMG_DVLD,
  output logic [15:0]       REG_IMG_DATA,
  output logic [IMG_AW-1:0] REG_ADDR
);

  generate
    if (DW != 32) begin : g_dw_check
      $error("uart_reg_bank_v2: DW must be 32");
    end
    if (AW < 8) begin : g_aw_check
      $error("uart_reg_bank_v2: AW must be at least 8");
    end
  endgenerate

  logic [DW-1:0]     r_vga;
  logic [DW-1:0]     r_sel;
  logic [DW-1:0]     r_img;
  logic [DW-1:0]     r_base;
  logic [15:0]       r_err_cnt;
  logic              r_wrap;

  logic [7:0]        w_off;
  logic              w_mapped;
  logic              w_rd_err;
  logic              w_wr_err;
  logic              w_wr_ok;
  logic              w_err;
  logic              w_img_start;
  logic              w_base_load;
  logic              w_clr_cnt;
  logic              w_clr_wrap;
  logic              w_busy;
  logic              w_wrap;
  logic [IMG_AW-1:0] w_ptr;
  logic [DW-1:0]     w_status;
  logic [DW-1:0]     w_rd_data;
  logic [15:0]       w_cnt_next;

  // Address decode and per-access error classification; read and write
  // share the address but are judged independently
  always_comb begin
    w_off       = UART_ADDR[7:0];
    w_mapped    = ((UART_ADDR >> 8) == '0) && reg_is_mapped(w_off);
    w_rd_err    = UART_STATE[0] && !w_mapped;
    w_wr_err    = UART_STATE[1] &&
                  (!w_mapped || reg_is_ro(w_off) || ((w_off == REG_IMG) && w_busy));
    w_wr_ok     = UART_STATE[1] && !w_wr_err;
    w_err       = w_rd_err || w_wr_err;
    w_img_start = w_wr_ok && (w_off == REG_IMG);
    w_base_load = w_wr_ok && (w_off == REG_BASE);
    w_clr_cnt   = w_wr_ok && (w_off == REG_STAT) && UART_DATA[ST_CNT_CLR_BIT];
    w_clr_wrap  = w_wr_ok && (w_off == REG_STAT) && UART_DATA[ST_WRAP_BIT];
  end

  // Status word and read mux, both built from pre-write register values
  always_comb begin
    w_status              = '0;
    w_status[15:0]        = r_err_cnt;
    w_status[ST_WRAP_BIT] = r_wrap;
    w_status[ST_BUSY_BIT] = w_busy;
    w_rd_data             = '0;
    if (w_mapped) begin
      case (w_off)
        REG_VER:  w_rd_data = VERSION;
        REG_DATE: w_rd_data = DATE;
        REG_VGA:  w_rd_data = r_vga;
        REG_SEL:  w_rd_data = r_sel;
        REG_IMG:  w_rd_data = r_img;
        REG_BASE: w_rd_data = r_base;
        REG_STAT: w_rd_data = w_status;
        REG_PTR:  w_rd_data = DW'(w_ptr);
        default:  w_rd_data = '0;
      endcase
    end
  end

  // Error counter: a clear in the same cycle as an error leaves it at 1
  always_comb begin
    w_cnt_next = w_clr_cnt ? 16'd0 : r_err_cnt;
    if (w_err && (w_cnt_next != 16'hFFFF)) w_cnt_next = w_cnt_next + 16'd1;
  end

  // Acks, read data and error flag, one cycle after the request
  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) begin
      REG_STATE <= '0;
      REG_DATA  <= '0;
      REG_ERR   <= 1'b0;
    end else begin
      REG_STATE <= UART_STATE;
      REG_DATA  <= UART_STATE[0] ? w_rd_data : '0;
      REG_ERR   <= w_err;
    end
  end

  // Writable registers and status; a wrap in the clearing cycle survives
  always_ff @(posedge CLK_100M or posedge SYS_RST) begin
    if (SYS_RST) begin
      r_vga     <= '0;
      r_sel     <= '0;
      r_img     <= '0;
      r_base    <= '0;
      r_err_cnt <= '0;
      r_wrap    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        case (w_off)
          REG_VGA:  r_vga  <= UART_DATA;
          REG_SEL:  r_sel  <= UART_DATA;
          REG_IMG:  r_img  <= UART_DATA;
          REG_BASE: r_base <= UART_DATA;
          default:  ;
        endcase
      end
      r_err_cnt <= w_cnt_next;
      if (w_wrap)          r_wrap <= 1'b1;
      else if (w_clr_wrap) r_wrap <= 1'b0;
    end
  end

  img_pix_emitter #(
    .IMG_AW   (IMG_AW),
    .IMG_DEPTH(IMG_DEPTH),
    .PIX_MODE (PIX_MODE)
  ) u_emitter (
    .CLK_100M   (CLK_100M),
    .SYS_RST    (SYS_RST),
    .i_start    (w_img_start),
    .i_word     (UART_DATA[31:0]),
    .i_load     (w_base_load),
    .i_load_addr(UART_DATA[IMG_AW-1:0]),
    .o_dvld     (REG_IMG_DVLD),
    .o_data     (REG_IMG_DATA),
    .o_addr     (REG_ADDR),
    .o_ptr      (w_ptr),
    .o_busy     (w_busy),
    .o_wrap     (w_wrap)
  );

  assign REG_VGA_EN = r_vga[0];
  assign REG_SELECT = {r_sel[4], r_sel[0]};

endmodule

// File: tb/tb_uart_reg_bank_v2.sv
// Bench for uart_reg_bank_v2: one instance per pixel mode on shared stimulus,
// directed scenarios then random traffic, checked against a pending-pixel
// list model of the register map.
module tb_uart_reg_bank_v2;

  localparam int unsigned DEPTH = 1 << 18;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  ust = '0;
  logic [7:0]  uaddr = '0;
  logic [31:0] udata = '0;

  logic [1:0]  reg_state [3];
  logic [31:0] reg_data  [3];
  logic        reg_err   [3];
  logic        vga_en    [3];
  logic [1:0]  sel       [3];
  logic        dvld      [3];
  logic [15:0] img_data  [3];
  logic [17:0] img_addr  [3];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      uart_reg_bank_v2 #(.PIX_MODE(gi)) u_dut (
        .CLK_100M    (clk),
        .SYS_RST     (rst),
        .UART_STATE  (ust),
        .UART_ADDR   (uaddr),
        .UART_DATA   (udata),
        .REG_STATE   (reg_state[gi]),
        .REG_DATA    (reg_data[gi]),
        .REG_ERR     (reg_err[gi]),
        .REG_VGA_EN  (vga_en[gi]),
        .REG_SELECT  (sel[gi]),
        .REG_IMG_DVLD(dvld[gi]),
        .REG_IMG_DATA(img_data[gi]),
        .REG_ADDR    (img_addr[gi])
      );
    end
  endgenerate

  int errors = 0;
  int checks = 0;

  // Reference state, one set per pixel mode
  int unsigned m_vga[3], m_sel[3], m_img[3], m_base[3], m_ptr[3], m_cnt[3];
  bit          m_wrap[3];
  int unsigned m_qd[3][2];   // pixels still to be strobed, front first
  int          m_qn[3];
  int unsigned m_last_d[3], m_last_a[3];
  logic [1:0]  e_state;
  logic [31:0] e_rdata[3];
  bit          e_err[3];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 3; m++) begin
      m_vga[m] = 0; m_sel[m] = 0; m_img[m] = 0; m_base[m] = 0;
      m_ptr[m] = 0; m_cnt[m] = 0; m_wrap[m] = 0; m_qn[m] = 0;
      m_qd[m][0] = 0; m_qd[m][1] = 0; m_last_d[m] = 0; m_last_a[m] = 0;
      e_rdata[m] = 0; e_err[m] = 0;
    end
    e_state = 0;
  endtask

  function automatic int unsigned to565(input int unsigned d);
    return (((d >> 19) & 31) << 11) | (((d >> 10) & 63) << 5) | ((d >> 3) & 31);
  endfunction

  // Apply one clock edge's worth of requests to the reference
  task automatic model_step(input logic [1:0] st, input logic [7:0] a, input logic [31:0] d);
    bit rd, wr, mp, busy, rd_err, wr_err, wr_ok, wrap_set, clr_cnt;
    logic [31:0] rv;
    int unsigned ai;
    ai = a;
    rd = st[0];
    wr = st[1];
    mp = (ai % 4 == 0) && (ai <= 28);
    for (int m = 0; m < 3; m++) begin
      busy   = (m_qn[m] > 0);
      rd_err = rd && !mp;
      wr_err = wr && (!mp || ai == 0 || ai == 4 || ai == 28 || (ai == 16 && busy));
      wr_ok  = wr && !wr_err;
      rv = 0;
      if (rd && mp) begin
        case (ai)
          0:  rv = 32'h0002_0000;
          4:  rv = 32'h0;
          8:  rv = m_vga[m];
          12: rv = m_sel[m];
          16: rv = m_img[m];
          20: rv = m_base[m];
          24: rv = m_cnt[m] + (m_wrap[m] ? 32'h1_0000 : 0) + (busy ? 32'h2_0000 : 0);
          default: rv = m_ptr[m];
        endcase
      end
      e_rdata[m] = rv;
      e_err[m]   = rd_err || wr_err;
      wrap_set = 0;
      clr_cnt  = 0;
      if (busy) begin
        m_last_d[m] = m_qd[m][0];
        m_last_a[m] = m_ptr[m];
        m_qd[m][0]  = m_qd[m][1];
        m_qn[m]--;
      end
      if (wr_ok && ai == 20) begin
        m_ptr[m] = d % DEPTH;
      end else if (busy) begin
        if (m_ptr[m] == DEPTH - 1) begin
          m_ptr[m] = 0;
          wrap_set = 1;
        end else begin
          m_ptr[m]++;
        end
      end
      if (wr_ok) begin
        case (ai)
          8:  m_vga[m] = d;
          12: m_sel[m] = d;
          16: begin
            m_img[m] = d;
            if (m == 1) begin
              m_qd[m][0] = to565(d); m_qn[m] = 1;
            end else if (m == 2) begin
              m_qd[m][0] = d % 65536; m_qd[m][1] = d / 65536; m_qn[m] = 2;
            end else begin
              m_qd[m][0] = d % 65536; m_qn[m] = 1;
            end
          end
          20: m_base[m] = d;
          24: begin
            if (d[16]) m_wrap[m] = 0;
            if (d[31]) clr_cnt = 1;
          end
          default: ;
        endcase
      end
      if (wrap_set) m_wrap[m] = 1;
      if (clr_cnt) m_cnt[m] = 0;
      if (e_err[m] && m_cnt[m] < 65535) m_cnt[m]++;
    end
    e_state = st;
  endtask

  task automatic check_outputs();
    for (int m = 0; m < 3; m++) begin
      check_val($sformatf("ack_m%0d", m), reg_state[m], e_state);
      if (e_state[0]) check_val($sformatf("rdata_m%0d", m), reg_data[m], e_rdata[m]);
      check_val($sformatf("err_m%0d", m), reg_err[m], e_err[m]);
      check_val($sformatf("vga_m%0d", m), vga_en[m], m_vga[m] & 1);
      check_val($sformatf("sel_m%0d", m), sel[m], (((m_sel[m] >> 4) & 1) << 1) | (m_sel[m] & 1));
      check_val($sformatf("dvld_m%0d", m), dvld[m], (m_qn[m] > 0));
      check_val($sformatf("pix_m%0d", m), img_data[m], (m_qn[m] > 0) ? m_qd[m][0] : m_last_d[m]);
      check_val($sformatf("paddr_m%0d", m), img_addr[m], (m_qn[m] > 0) ? m_ptr[m] : m_last_a[m]);
    end
  endtask

  // One clock: drive, advance the reference, sample 1 ns after the edge
  task automatic do_cycle(input logic [1:0] st, input logic [7:0] a, input logic [31:0] d);
    ust = st; uaddr = a; udata = d;
    model_step(st, a, d);
    @(posedge clk);
    #1;
    ust = 2'b00;
    check_outputs();
    if (st != 2'b00)
      $display("txn st=%b addr=%02h data=%08h -> rdata=%08h err=%b dvld=%b%b%b",
               st, a, d, reg_data[0], reg_err[0], dvld[0], dvld[1], dvld[2]);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) do_cycle(2'b00, 8'h00, 32'h0);
  endtask

  initial begin
    model_reset();
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int m = 0; m < 3; m++) begin
      check_val("rst_ack", reg_state[m], 0);
      check_val("rst_err", reg_err[m], 0);
      check_val("rst_data", reg_data[m], 0);
      check_val("rst_vga", vga_en[m], 0);
      check_val("rst_sel", sel[m], 0);
      check_val("rst_dvld", dvld[m], 0);
      check_val("rst_pix", img_data[m], 0);
      check_val("rst_paddr", img_addr[m], 0);
    end
    rst = 1'b0;

    // Identity registers
    do_cycle(2'b01, 8'h00, 32'h0);
    check_val("version", reg_data[0], 32'h0002_0000);
    do_cycle(2'b01, 8'h04, 32'h0);

    // Control registers and a rejected write to a read-only register
    do_cycle(2'b10, 8'h08, 32'h1);
    check_val("vga_en_on", vga_en[0], 1);
    do_cycle(2'b10, 8'h0C, 32'h11);
    check_val("select_11", sel[0], 2'b11);
    do_cycle(2'b10, 8'h00, 32'hDEAD_BEEF);
    check_val("ro_write_err", reg_err[0], 1);
    do_cycle(2'b01, 8'h00, 32'h0);
    do_cycle(2'b01, 8'h18, 32'h0);
    check_val("err_count_1", reg_data[0] & 32'hFFFF, 1);
    do_cycle(2'b01, 8'h02, 32'h0);   // unaligned read

    // Pointer wrap across three writes
    do_cycle(2'b10, 8'h14, 32'h0003_FFFE);
    do_cycle(2'b10, 8'h10, 32'h0000_AAAA);
    check_val("m0_addr_a", img_addr[0], 18'h3FFFE);
    idle(2);
    do_cycle(2'b10, 8'h10, 32'h0000_BBBB);
    check_val("m0_addr_b", img_addr[0], 18'h3FFFF);
    idle(2);
    do_cycle(2'b10, 8'h10, 32'h0000_CCCC);
    check_val("m0_addr_c", img_addr[0], 18'h00000);
    check_val("m0_pix_c", img_data[0], 16'hCCCC);
    idle(2);
    do_cycle(2'b01, 8'h18, 32'h0);
    check_val("wrap_set", (reg_data[0] >> 16) & 1, 1);
    do_cycle(2'b10, 8'h18, 32'h0001_0000);
    do_cycle(2'b01, 8'h18, 32'h0);
    check_val("wrap_clr", (reg_data[0] >> 16) & 1, 0);

    // Two pixels per word; a write during the first strobe is dropped
    do_cycle(2'b10, 8'h10, 32'h1234_5678);
    check_val("m2_pix0", img_data[2], 16'h5678);
    do_cycle(2'b10, 8'h10, 32'hDEAD_BEEF);
    check_val("m2_busy_err", reg_err[2], 1);
    check_val("m2_pix1", img_data[2], 16'h1234);
    idle(2);
    check_val("m2_no_third", dvld[2], 0);

    // RGB888 truncation
    do_cycle(2'b10, 8'h10, 32'h00FF_8040);
    check_val("m1_rgb565", img_data[1], 16'hFC08);
    idle(2);

    // Simultaneous read and write returns the old value
    do_cycle(2'b10, 8'h08, 32'h0);
    do_cycle(2'b11, 8'h08, 32'h1);
    check_val("rw_old", reg_data[0], 0);
    check_val("rw_acks", reg_state[0], 2'b11);

    // Reset in the middle of a strobe
    do_cycle(2'b10, 8'h10, 32'h5555_6666);
    #2 rst = 1'b1;
    #1;
    for (int m = 0; m < 3; m++) check_val("rst_mid_dvld", dvld[m], 0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    do_cycle(2'b01, 8'h1C, 32'h0);
    check_val("rst_ptr", reg_data[0], 0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int unsigned r, k;
      logic [1:0]  st;
      logic [7:0]  a;
      logic [31:0] d;
      r  = $urandom_range(0, 99);
      st = (r < 30) ? 2'b00 : (r < 55) ? 2'b01 : (r < 85) ? 2'b10 : 2'b11;
      k  = $urandom_range(0, 9);
      if (k < 8)       a = 8'(k * 4);
      else if (k == 8) a = 8'($urandom_range(0, 255));
      else             a = 8'(($urandom_range(0, 7) * 4) + $urandom_range(1, 3));
      d = $urandom;
      if (a == 8'h14 && $urandom_range(0, 1) == 1) d = 32'h0003_FFFC + $urandom_range(0, 3);
      do_cycle(st, a, d);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_reg_bank_v2.md
Name: uart_reg_bank_v2

Overview:
Parametrised control/status register bank between the UART command controller and the VGA/image-store path.
- Decodes UART read/write requests against a word-addressed register map.
- Provides read-only identity registers and flags illegal accesses.
- Converts writes to the image-data register into one or two pixel strobes, carrying an auto-incrementing store address.
- Drives VGA enable/select and the image write port of the frame store.

Parameters:
AW, 8, UART address width (byte address; registers at multiples of 4)
DW, 32, UART data width (fixed 32 in this generation; checked at elaboration)
IMG_AW, 18, image store address width
IMG_DEPTH, 2**18, store depth; pointer wraps at IMG_DEPTH-1
PIX_MODE, 0, 0: one RGB565 pixel per write = DATA[15:0]; 1: RGB888 DATA[23:0] truncated to 565; 2: two RGB565 pixels per write, DATA[15:0] first then DATA[31:16]
VERSION, 32'h0002_0000, value of reg 0x00
DATE, 32'h0000_0000, value of reg 0x04

Ports:
CLK_100M  in  1  100 MHz clock
SYS_RST  in  1  reset, asynchronous, active-high
UART_STATE  in  2  [1] write request, [0] read request; single-cycle pulses
UART_ADDR  in  AW  byte address
UART_DATA  in  DW  write data
REG_STATE  out  2  [1] write ack, [0] read ack; one-cycle pulses
REG_DATA  out  DW  read data, valid only with REG_STATE[0]
REG_ERR  out  1  one-cycle pulse, coincident with the ack of a rejected access
REG_VGA_EN  out  1  reg 0x08 bit 0
REG_SELECT  out  2  {reg 0x0C[4], reg 0x0C[0]}
REG_IMG_DVLD  out  1  pixel strobe
REG_IMG_DATA  out  16  RGB565 pixel
REG_ADDR  out  IMG_AW  store address of the current pixel

Behaviour:
- Reset: all outputs 0; regs 0x08/0x0C/0x10/0x14/0x18 = 0; pixel pointer = 0; pixel FSM = IDLE.
- Register map:
  - 0x00 VERSION (RO)
  - 0x04 DATE (RO)
  - 0x08 VGA ctrl (RW)
  - 0x0C select (RW)
  - 0x10 image data (WO; reads return last written word)
  - 0x14 base address (RW; write also loads pointer = DATA[IMG_AW-1:0])
  - 0x18 status (RO except W1C): [15:0] saturating error count, [16] sticky wrap flag, [17] pixel FSM busy, [31:18] 0
  - 0x1C pointer (RO)
- Latency: request at cycle t -> ack, REG_DATA and REG_ERR at t+1. A written register is visible on its outputs at t+1.
- Read of an unmapped address: REG_DATA = 0, REG_ERR = 1, ack still issued.
- Rejected writes, each acked with REG_ERR = 1 and register unchanged:
  - unmapped address
  - write to a RO register (0x00, 0x04, 0x1C)
  - write to 0x10 while the pixel FSM is busy; the write is dropped
- Write to 0x18: clear-on-1 only. bit 16 clears the wrap flag; bit 31 clears the error count. Write is not an error.
- Unaligned address (UART_ADDR[1:0] != 0) is treated as unmapped.
- Simultaneous read+write in the same cycle: both acked at t+1. The read returns the pre-write value. Each access checked independently for errors; REG_ERR = OR of the two.
- Error count: +1 per cycle in which REG_ERR is asserted, saturating at 16'hFFFF. A clear and an error in the same cycle -> count = 1.
- Pixel FSM:
  - IDLE: on accepted write to 0x10 -> EMIT0, and capture the word.
  - EMIT0 (cycle t+1): DVLD = 1, DATA = pixel0, ADDR = ptr; then ptr advances. Next state is EMIT1 if PIX_MODE = 2, else IDLE.
  - EMIT1 (t+2): DVLD = 1, DATA = pixel1 = word[31:16], ADDR = advanced ptr; then ptr advances -> IDLE.
  - Busy = state != IDLE; a 0x10 write in the EMIT0 cycle of mode 2 is rejected.
- Pointer advance: ptr == IMG_DEPTH-1 -> 0, sets wrap flag; else ptr + 1.
- Write to 0x14 during EMIT0/EMIT1: the new load takes priority over that cycle's increment. The next pixel uses the loaded address.
- RGB888 -> 565: {D[23:19], D[15:10], D[7:3]}.
- REG_IMG_DATA/REG_ADDR hold their last values when DVLD = 0.
- SYS_RST mid-emit: FSM -> IDLE immediately, DVLD = 0, pending pixel discarded.

Decomposition:
- Package uart_reg_pkg:
  - register offset constants (REG_VER = 8'h00 … REG_PTR = 8'h1C)
  - pixel FSM state enum {IDLE, EMIT0, EMIT1}
  - PIX_MODE encodings
  - status bit positions
- One sub-module, img_pix_emitter: pixel FSM, format conversion, pointer/wrap logic. The top module keeps decode, registers, acks and errors.

Test Plan:
- Reset, then read 0x00 and 0x04 -> REG_DATA = VERSION/DATE at t+1, REG_ERR = 0; all outputs 0 during reset.
- Write 0x08 = 1, 0x0C = 0x11 -> REG_VGA_EN = 1, REG_SELECT = 2'b11 at t+1; write to 0x00 -> REG_ERR = 1, VERSION unchanged, status[15:0] = 1.
- PIX_MODE 0: write 0x14 = 0x3FFFE, then 0x10 three times with 0xAAAA, 0xBBBB, 0xCCCC -> DVLD pulses with (addr, data) = (0x3FFFE, AAAA), (0x3FFFF, BBBB), (0x00000, CCCC); status[16] = 1; write 0x18 = 0x10000 -> bit 16 = 0.
- PIX_MODE 2: write 0x10 = 0x1234_5678 -> DVLD at t+1 (5678, ptr) and t+2 (1234, ptr+1); a second 0x10 write at t+1 -> REG_ERR = 1, dropped, no third pixel.
- PIX_MODE 1: write 0x10 = 0x00FF8040 -> REG_IMG_DATA = 16'hFC08.
- Simultaneous read+write of 0x08 (old 0, new 1) -> REG_DATA = 0, both acks; then assert SYS_RST during EMIT0 -> DVLD drops at once, pointer = 0.
